store_buffer: RTL and testbench

- Posted-write buffer directly upstream of the data memory in the 16-bit core.
- Accepts stores from the MEM stage, queues them in a FIFO and drains one per cycle into the data memory (MemWrite/BH/Address/WriteData interface).
- Loads from the MEM stage get priority on the memory port. A load that fully matches a buffered store is forwarded from the buffer; a load that only partly overlaps a buffered store stalls until the buffer has drained.

---
 rtl/store_buffer.sv | 148 ++++++++++++++
 tb/tb_store_buffer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Posted-write store buffer sitting in front of the data memory.
// Stores are queued in a circular FIFO and retired one per cycle. Loads get
// the memory port first, are forwarded from the youngest matching entry, or
// stall while a partially overlapping entry is still buffered.
module store_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          st_valid,
   output logic          st_ready,
   input  logic [AW-1:0] st_addr,
   input  logic [15:0]   st_data,
   input  logic          st_bh,
   input  logic          ld_req,
   input  logic [AW-1:0] ld_addr,
   input  logic          ld_bh,
   output logic          ld_hit,
   output logic [15:0]   ld_data,
   output logic          ld_stall,
   output logic          MemRead,
   output logic          MemWrite,
   output logic          BH,
   output logic [AW-1:0] Address,
   output logic [15:0]   WriteData
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0] r_addr [DEPTH];
   logic [15:0]   r_data [DEPTH];
   logic          r_bh   [DEPTH];
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;

   logic          w_any;
   logic [AW-1:0] w_sel_addr;
   logic [15:0]   w_sel_data;
   logic          w_sel_bh;
   logic [PW-1:0] w_idx;
   logic [AW-1:0] w_ea;
   logic [AW-1:0] w_ea_hi;
   logic          w_eb;
   logic          w_ovl;
   logic [AW-1:0] w_ld_hi;
   logic          w_hit;
   logic          w_rd;
   logic          w_drain;
   logic          w_enq;
   logic          w_ready;

   // Walk the valid entries oldest to youngest; the last overlap seen is the youngest.
   always_comb begin
      w_any      = 1'b0;
      w_sel_addr = '0;
      w_sel_data = '0;
      w_sel_bh   = 1'b0;
      w_idx      = '0;
      w_ea       = '0;
      w_ea_hi    = '0;
      w_eb       = 1'b0;
      w_ovl      = 1'b0;
      w_ld_hi    = ld_addr + AW'(1);
      for (int k = 0; k < DEPTH; k++) begin
         w_idx   = r_head + PW'(k);
         w_ea    = r_addr[w_idx];
         w_eb    = r_bh[w_idx];
         w_ea_hi = w_ea + AW'(1);
         w_ovl   = (w_ea == ld_addr) || (w_eb && (w_ea_hi == ld_addr)) ||
                   (ld_bh && (w_ld_hi == w_ea));
         if ((CW'(k) < r_count) && w_ovl) begin
            w_any      = 1'b1;
            w_sel_addr = w_ea;
            w_sel_data = r_data[w_idx];
            w_sel_bh   = w_eb;
         end
      end
   end

   // Forwarding decision and single-port arbitration: a clean load wins, otherwise drain the head.
   always_comb begin
      w_ready = (r_count != CW'(DEPTH));
      w_enq   = !reset && st_valid && w_ready;
      w_hit   = ld_req && w_any && (w_sel_addr == ld_addr) && (w_sel_bh || !ld_bh);
      w_rd    = ld_req && !w_any;
      w_drain = !reset && !w_rd && (r_count != '0);
   end

   // Drive the outputs; everything is forced low while reset is asserted.
   always_comb begin
      st_ready  = 1'b0;
      ld_hit    = 1'b0;
      ld_data   = '0;
      ld_stall  = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      BH        = 1'b0;
      Address   = '0;
      WriteData = '0;
      if (!reset) begin
         st_ready = w_ready;
         ld_hit   = w_hit;
         ld_stall = ld_req && w_any && !w_hit;
         if (w_hit)
            ld_data = ld_bh ? w_sel_data : {8'h00, w_sel_data[7:0]};
         if (w_rd) begin
            MemRead = 1'b1;
            Address = ld_addr;
         end else if (w_drain) begin
            MemWrite  = 1'b1;
            Address   = r_addr[r_head];
            WriteData = r_data[r_head];
            BH        = r_bh[r_head];
         end
      end
   end

   // Entry storage; contents are only meaningful while counted as valid.
   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_addr[r_tail] <= st_addr;
         r_data[r_tail] <= st_data;
         r_bh[r_tail]   <= st_bh;
      end
   end

   // Pointer and occupancy bookkeeping; reset discards any pending stores.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_enq)
            r_tail <= r_tail + PW'(1);
         if (w_drain)
            r_head <= r_head + PW'(1);
         if (w_enq && !w_drain)
            r_count <= r_count + CW'(1);
         else if (!w_enq && w_drain)
            r_count <= r_count - CW'(1);
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Testbench for store_buffer: forwarding vector table, hand-written
// multi-cycle sequences and random traffic against a queue-based model.
module tb_store_buffer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        st_valid;
   logic        st_ready;
   logic [15:0] st_addr;
   logic [15:0] st_data;
   logic        st_bh;
   logic        ld_req;
   logic [15:0] ld_addr;
   logic        ld_bh;
   logic        ld_hit;
   logic [15:0] ld_data;
   logic        ld_stall;
   logic        MemRead;
   logic        MemWrite;
   logic        BH;
   logic [15:0] Address;
   logic [15:0] WriteData;

   store_buffer #(.DEPTH(DEPTH), .AW(16)) dut (
      .clk(clk), .reset(reset),
      .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
      .st_data(st_data), .st_bh(st_bh),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_bh(ld_bh),
      .ld_hit(ld_hit), .ld_data(ld_data), .ld_stall(ld_stall),
      .MemRead(MemRead), .MemWrite(MemWrite), .BH(BH),
      .Address(Address), .WriteData(WriteData)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] d;
      logic        bh;
   } ent_t;

   ent_t q[$];
   logic [15:0] wlog[$];

   int total = 0;
   int bad   = 0;

   logic        s_ready, s_hit, s_stall, s_rd, s_wr, s_bh;
   logic [15:0] s_data, s_addr, s_wdata;

   localparam logic [15:0] HOLD = 16'h8000;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit overlaps(input ent_t e, input logic [15:0] la, input logic lbh);
      logic [15:0] eb [2];
      logic [15:0] lb [2];
      int ne;
      int nl;
      eb[0] = e.a;  eb[1] = e.a + 16'd1;
      lb[0] = la;   lb[1] = la + 16'd1;
      ne = e.bh ? 2 : 1;
      nl = lbh ? 2 : 1;
      for (int i = 0; i < ne; i++)
         for (int j = 0; j < nl; j++)
            if (eb[i] == lb[j]) return 1'b1;
      return 1'b0;
   endfunction

   // One clock cycle: drive, let combinational outputs settle, compare with the model, advance the model.
   task automatic step(input logic rst, input logic sv, input logic [15:0] sa, input logic [15:0] sd,
                       input logic sbh, input logic lr, input logic [15:0] la, input logic lbh);
      bit          found;
      ent_t        sel;
      logic        e_ready, e_hit, e_stall, e_rd, e_wr, e_bh;
      logic [15:0] e_data, e_addr, e_wdata;
      @(negedge clk);
      reset = rst; st_valid = sv; st_addr = sa; st_data = sd; st_bh = sbh;
      ld_req = lr; ld_addr = la; ld_bh = lbh;
      #1;
      found = 1'b0;
      sel   = '{16'h0, 16'h0, 1'b0};
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (overlaps(q[i], la, lbh)) begin
            found = 1'b1;
            sel   = q[i];
            break;
         end
      end
      e_ready = 1'b0; e_hit = 1'b0; e_stall = 1'b0; e_rd = 1'b0; e_wr = 1'b0; e_bh = 1'b0;
      e_data = 16'h0; e_addr = 16'h0; e_wdata = 16'h0;
      if (!rst) begin
         e_ready = (q.size() < DEPTH);
         e_hit   = lr && found && (sel.a == la) && (sel.bh || !lbh);
         e_stall = lr && found && !e_hit;
         if (e_hit) e_data = lbh ? sel.d : {8'h00, sel.d[7:0]};
         e_rd    = lr && !found;
         e_wr    = !e_rd && (q.size() > 0);
         if (e_rd) e_addr = la;
         else if (e_wr) begin
            e_addr = q[0].a; e_wdata = q[0].d; e_bh = q[0].bh;
         end
      end
      s_ready = st_ready; s_hit = ld_hit; s_stall = ld_stall; s_rd = MemRead;
      s_wr = MemWrite; s_bh = BH; s_data = ld_data; s_addr = Address; s_wdata = WriteData;
      chk("model st_ready",  {15'h0, s_ready}, {15'h0, e_ready});
      chk("model ld_hit",    {15'h0, s_hit},   {15'h0, e_hit});
      chk("model ld_stall",  {15'h0, s_stall}, {15'h0, e_stall});
      chk("model ld_data",   s_data,  e_data);
      chk("model MemRead",   {15'h0, s_rd},    {15'h0, e_rd});
      chk("model MemWrite",  {15'h0, s_wr},    {15'h0, e_wr});
      chk("model BH",        {15'h0, s_bh},    {15'h0, e_bh});
      chk("model Address",   s_addr,  e_addr);
      chk("model WriteData", s_wdata, e_wdata);
      if (s_wr) wlog.push_back(s_addr);
      if (rst) q.delete();
      else begin
         if (e_wr) void'(q.pop_front());
         if (sv && e_ready) q.push_back('{sa, sd, sbh});
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
   endtask

   // Store while a non-overlapping load holds the memory port, so the entry stays buffered.
   task automatic held_store(input logic [15:0] a, input logic [15:0] d, input logic bh);
      step(1'b0, 1'b1, a, d, bh, 1'b1, HOLD, 1'b1);
   endtask

   typedef struct {
      logic [15:0] a0; logic [15:0] d0; logic b0;
      logic        two;
      logic [15:0] a1; logic [15:0] d1; logic b1;
      logic [15:0] la; logic lb;
      logic hit; logic [15:0] data; logic stall; logic rd;
   } vec_t;

   vec_t vt [12];

   initial begin
      int guard;
      reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_bh = 1'b0;
      ld_req = 1'b0; ld_addr = '0; ld_bh = 1'b0;

      vt[0]  = '{16'h0010, 16'hBEEF, 1'b1, 1'b1, 16'h0100, 16'h1234, 1'b1, 16'h0010, 1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0};
      vt[1]  = '{16'h0010, 16'hBEEF, 1'b1, 1'b1, 16'h0100, 16'h1234, 1'b1, 16'h0010, 1'b0, 1'b1, 16'h00EF, 1'b0, 1'b0};
      vt[2]  = '{16'h0010, 16'hBEEF, 1'b1, 1'b1, 16'h0100, 16'h1234, 1'b1, 16'h0011, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      vt[3]  = '{16'h0020, 16'h1111, 1'b1, 1'b1, 16'h0020, 16'h2222, 1'b1, 16'h0020, 1'b1, 1'b1, 16'h2222, 1'b0, 1'b0};
      vt[4]  = '{16'h0031, 16'h00AB, 1'b0, 1'b1, 16'h0100, 16'h1234, 1'b1, 16'h0030, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
      vt[5]  = '{16'h0000, 16'h0055, 1'b0, 1'b1, 16'h0100, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
      vt[6]  = '{16'h0040, 16'h12CD, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0040, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
      vt[7]  = '{16'h0040, 16'h12CD, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0040, 1'b0, 1'b1, 16'h00CD, 1'b0, 1'b0};
      vt[8]  = '{16'h0010, 16'hBEEF, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0050, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
      vt[9]  = '{16'hFFFF, 16'hA55A, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      vt[10] = '{16'h0020, 16'h1111, 1'b1, 1'b1, 16'h0021, 16'h0099, 1'b0, 16'h0020, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
      vt[11] = '{16'h0021, 16'h0099, 1'b0, 1'b1, 16'h0020, 16'h3344, 1'b1, 16'h0020, 1'b1, 1'b1, 16'h3344, 1'b0, 1'b0};

      do_reset();
      do_reset();
      chk("reset MemWrite", {15'h0, s_wr}, 16'h0);
      chk("reset st_ready", {15'h0, s_ready}, 16'h0);

      // Forwarding / stall table
      for (int v = 0; v < 12; v++) begin
         do_reset();
         held_store(vt[v].a0, vt[v].d0, vt[v].b0);
         if (vt[v].two) held_store(vt[v].a1, vt[v].d1, vt[v].b1);
         else step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, HOLD, 1'b1);
         step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, vt[v].la, vt[v].lb);
         chk($sformatf("vec%0d ld_hit", v),   {15'h0, s_hit},   {15'h0, vt[v].hit});
         chk($sformatf("vec%0d ld_data", v),  s_data,           vt[v].data);
         chk($sformatf("vec%0d ld_stall", v), {15'h0, s_stall}, {15'h0, vt[v].stall});
         chk($sformatf("vec%0d MemRead", v),  {15'h0, s_rd},    {15'h0, vt[v].rd});
      end

      // Reset flush
      do_reset();
      held_store(16'h0100, 16'h0001, 1'b1);
      held_store(16'h0102, 16'h0002, 1'b1);
      held_store(16'h0104, 16'h0003, 1'b1);
      do_reset();
      for (int i = 0; i < 4; i++) begin
         idle(1);
         chk("flush MemWrite", {15'h0, s_wr}, 16'h0);
         chk("flush st_ready", {15'h0, s_ready}, 16'h1);
      end

      // Fill and backpressure
      do_reset();
      for (int i = 0; i < 4; i++) held_store(16'(2 * i), 16'hA000 + 16'(i), 1'b1);
      held_store(16'h0008, 16'hA004, 1'b1);
      chk("full st_ready", {15'h0, s_ready}, 16'h0);
      wlog.delete();
      guard = 0;
      do begin
         step(1'b0, 1'b1, 16'h0008, 16'hA004, 1'b1, 1'b0, 16'h0, 1'b0);
         guard++;
      end while (!s_ready && guard < 10);
      chk("fill accept in bound", {15'h0, s_ready}, 16'h1);
      idle(6);
      chk("fill write count", 16'(wlog.size()), 16'd5);
      for (int i = 0; i < 5 && i < wlog.size(); i++) chk("fill write order", wlog[i], 16'(2 * i));

      // Load priority over draining
      do_reset();
      held_store(16'h0200, 16'h5555, 1'b1);
      held_store(16'h0202, 16'h6666, 1'b1);
      step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 16'h0300, 1'b1);
      chk("prio MemRead",  {15'h0, s_rd}, 16'h1);
      chk("prio MemWrite", {15'h0, s_wr}, 16'h0);
      chk("prio Address",  s_addr, 16'h0300);
      idle(1);
      chk("prio drain MemWrite", {15'h0, s_wr}, 16'h1);
      chk("prio drain Address",  s_addr, 16'h0200);
      idle(1);
      chk("prio drain2 Address", s_addr, 16'h0202);
      idle(1);
      chk("prio empty MemWrite", {15'h0, s_wr}, 16'h0);

      // Partial overlap stall clears once the entry retires
      do_reset();
      held_store(16'h0031, 16'h00AB, 1'b0);
      step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 16'h0030, 1'b1);
      chk("stall ld_stall", {15'h0, s_stall}, 16'h1);
      chk("stall drain",    {15'h0, s_wr},    16'h1);
      chk("stall drain addr", s_addr, 16'h0031);
      step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 16'h0030, 1'b1);
      chk("unstall ld_stall", {15'h0, s_stall}, 16'h0);
      chk("unstall MemRead",  {15'h0, s_rd},    16'h1);
      chk("unstall Address",  s_addr, 16'h0030);

      // Random traffic against the model
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         logic [15:0] ra, la;
         ra = ($urandom_range(0, 1) != 0) ? (16'hFFF8 | 16'($urandom_range(0, 7)))
                                          : 16'($urandom_range(0, 7));
         la = ($urandom_range(0, 1) != 0) ? (16'hFFF8 | 16'($urandom_range(0, 7)))
                                          : 16'($urandom_range(0, 7));
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) != 0), ra, 16'($urandom),
              ($urandom_range(0, 1) != 0), ($urandom_range(0, 9) < 5), la, ($urandom_range(0, 1) != 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
